ucode_sequencer: RTL and testbench



---
 rtl/ucseq_pkg.sv | 38 +++
 rtl/ucseq_pc_counter.sv | 27 ++
 rtl/ucode_sequencer.sv | 114 +++++++++++
 tb/tb_ucode_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ucseq_pkg.sv
// Shared constants, step FSM state type and microcode address packing for
// the microcode fetch/phase sequencer.
package ucseq_pkg;

  localparam int PC_W    = 12;
  localparam int OPC_W   = 4;
  localparam int OPR_W   = 4;
  localparam int UADDR_W = 7;

  // Bit positions inside ucode_addr
  localparam int UA_OPC_MSB   = 6;
  localparam int UA_OPC_LSB   = 3;
  localparam int UA_C_BIT     = 2;
  localparam int UA_Z_BIT     = 1;
  localparam int UA_PHASE_BIT = 0;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } step_state_t;

  function automatic logic [UADDR_W-1:0] pack_uaddr(
    input logic [OPC_W-1:0] opc,
    input logic             c,
    input logic             z,
    input logic             ph
  );
    logic [UADDR_W-1:0] a;
    a                         = '0;
    a[UA_OPC_MSB:UA_OPC_LSB]  = opc;
    a[UA_C_BIT]               = c;
    a[UA_Z_BIT]               = z;
    a[UA_PHASE_BIT]           = ph;
    return a;
  endfunction

endpackage

// File: rtl/ucseq_pc_counter.sv
// Program counter: load beats increment beats hold, wraps modulo 2^PC_W.
module ucseq_pc_counter
  import ucseq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_value,
  output logic [PC_W-1:0] pc
);

  // PC register with load/inc/hold priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (en) begin
      if (load) begin
        pc <= load_value;
      end else if (inc) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Instruction-fetch and phase sequencer feeding the microcode ROM.
// Optional single-step control is built when UCSEQ_STEP_EN is defined.
//
// Step FSM (UCSEQ_STEP_EN only):
//   state | meaning
//   HALT  | registers frozen, phase 0, waiting for a step_req rising edge
//   FETCH | fetch cycle of the stepped instruction
//   EXEC  | execute cycle; returns to HALT and pulses step_ack
module ucode_sequencer
  import ucseq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [OPC_W+OPR_W-1:0]   program_byte,
  input  logic                     inc_pc,
  input  logic                     load_pc,
  input  logic [PC_W-1:0]          pc_load_value,
  input  logic                     load_flags,
  input  logic                     alu_c,
  input  logic                     alu_z,
`ifdef UCSEQ_STEP_EN
  input  logic                     step_req,
  output logic                     step_ack,
`endif
  output logic [PC_W-1:0]          pc,
  output logic [OPR_W-1:0]         operand,
  output logic [UADDR_W-1:0]       ucode_addr,
  output logic                     phase
);

  logic                   run;
  logic                   phase_q;
  logic [OPC_W+OPR_W-1:0] ir;
  logic                   c_flag;
  logic                   z_flag;

`ifdef UCSEQ_STEP_EN
  step_state_t state;
  step_state_t state_nxt;
  logic        step_req_d;
  logic        step_edge;

  assign step_edge = step_req & ~step_req_d;

  // Step FSM state register, request edge history and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HALT;
      step_req_d <= 1'b0;
      step_ack   <= 1'b0;
    end else begin
      step_ack <= enable && (state == EXEC);
      if (enable) begin
        state      <= state_nxt;
        step_req_d <= step_req;
      end
    end
  end

  // Step FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HALT:    if (step_edge) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // Step FSM output: datapath advances only while an instruction is stepping
  always_comb begin
    run = 1'b0;
    if (enable && (state != HALT)) run = 1'b1;
  end
`else
  assign run = enable;
`endif

  ucseq_pc_counter u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run),
    .inc        (inc_pc),
    .load       (load_pc),
    .load_value (pc_load_value),
    .pc         (pc)
  );

  // Phase toggle, instruction capture in fetch, flag capture in execute
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      ir      <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
    end else if (run) begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        ir <= program_byte;
      end
      if (phase_q && load_flags) begin
        c_flag <= alu_c;
        z_flag <= alu_z;
      end
    end
  end

  assign phase      = phase_q;
  assign operand    = ir[OPR_W-1:0];
  assign ucode_addr = pack_uaddr(ir[OPC_W+OPR_W-1:OPR_W], c_flag, z_flag, phase_q);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed self-checking bench for ucode_sequencer (both UCSEQ_STEP_EN builds).
module tb_ucode_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  program_byte;
  logic        inc_pc;
  logic        load_pc;
  logic [11:0] pc_load_value;
  logic        load_flags;
  logic        alu_c;
  logic        alu_z;
  logic [11:0] pc;
  logic [3:0]  operand;
  logic [6:0]  ucode_addr;
  logic        phase;
`ifdef UCSEQ_STEP_EN
  logic        step_req;
  logic        step_ack;
`endif

  int tests;
  int fails;

  ucode_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .program_byte  (program_byte),
    .inc_pc        (inc_pc),
    .load_pc       (load_pc),
    .pc_load_value (pc_load_value),
    .load_flags    (load_flags),
    .alu_c         (alu_c),
    .alu_z         (alu_z),
`ifdef UCSEQ_STEP_EN
    .step_req      (step_req),
    .step_ack      (step_ack),
`endif
    .pc            (pc),
    .operand       (operand),
    .ucode_addr    (ucode_addr),
    .phase         (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    enable        = 1'b0;
    program_byte  = 8'h00;
    inc_pc        = 1'b0;
    load_pc       = 1'b0;
    pc_load_value = 12'h000;
    load_flags    = 1'b0;
    alu_c         = 1'b0;
    alu_z         = 1'b0;
`ifdef UCSEQ_STEP_EN
    step_req      = 1'b0;
`endif
    tick();
    tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_uaddr", 32'(ucode_addr), 32'h00);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_operand", 32'(operand), 32'h0);
`ifdef UCSEQ_STEP_EN
    check("rst_ack", 32'(step_ack), 32'h0);
`endif
    rst_n = 1'b1;

`ifdef UCSEQ_STEP_EN
    // Halted: enable alone does not run anything
    enable = 1'b1; program_byte = 8'h25; inc_pc = 1'b1;
    tick();
    check("halt_pc", 32'(pc), 32'h0);
    check("halt_phase", 32'(phase), 32'h0);

    // Request edge; step_req held 6 cycles
    step_req = 1'b1;
    tick();                                   // edge sampled, HALT -> FETCH
    check("s1_edge_pc", 32'(pc), 32'h0);
    check("s1_edge_ack", 32'(step_ack), 32'h0);
    tick();                                   // fetch
    check("s1_fetch_pc", 32'(pc), 32'h1);
    check("s1_fetch_uaddr", 32'(ucode_addr), 32'h11);
    check("s1_fetch_ack", 32'(step_ack), 32'h0);
    inc_pc = 1'b0;
    tick();                                   // exec -> HALT
    check("s1_exec_ack", 32'(step_ack), 32'h1);
    check("s1_exec_uaddr", 32'(ucode_addr), 32'h10);
    inc_pc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();                                 // still held high, no retrigger
      check("s1_hold_ack", 32'(step_ack), 32'h0);
      check("s1_hold_pc", 32'(pc), 32'h1);
      check("s1_hold_phase", 32'(phase), 32'h0);
    end

    // Second request runs the next instruction
    step_req = 1'b0;
    tick();
    step_req = 1'b1; program_byte = 8'h3C;
    tick();
    check("s2_edge_pc", 32'(pc), 32'h1);
    tick();
    check("s2_fetch_pc", 32'(pc), 32'h2);
    check("s2_fetch_uaddr", 32'(ucode_addr), 32'h19);
    check("s2_fetch_operand", 32'(operand), 32'hC);
    inc_pc = 1'b0;
    tick();
    check("s2_exec_ack", 32'(step_ack), 32'h1);
    check("s2_exec_uaddr", 32'(ucode_addr), 32'h18);
    tick();
    check("s2_after_ack", 32'(step_ack), 32'h0);
`else
    // First fetch
    enable = 1'b1; program_byte = 8'h25; inc_pc = 1'b1;
    tick();
    check("f1_pc", 32'(pc), 32'h1);
    check("f1_uaddr", 32'(ucode_addr), 32'h11);
    check("f1_operand", 32'(operand), 32'h5);

    // Exec: load beats inc; program_byte ignored
    load_pc = 1'b1; pc_load_value = 12'h3A0; program_byte = 8'h99;
    tick();
    check("e1_pc", 32'(pc), 32'h3A0);
    check("e1_uaddr", 32'(ucode_addr), 32'h10);
    check("e1_operand", 32'(operand), 32'h5);

    // enable low freezes everything
    enable = 1'b0; load_pc = 1'b0;
    tick();
    tick();
    check("frz_pc", 32'(pc), 32'h3A0);
    check("frz_uaddr", 32'(ucode_addr), 32'h10);

    // Jump to FFF during fetch, hold in exec, wrap on next fetch
    enable = 1'b1; load_pc = 1'b1; pc_load_value = 12'hFFF; program_byte = 8'h3C;
    tick();
    check("j_pc", 32'(pc), 32'hFFF);
    check("j_uaddr", 32'(ucode_addr), 32'h19);
    load_pc = 1'b0; inc_pc = 1'b0;
    tick();
    check("hold_pc", 32'(pc), 32'hFFF);
    inc_pc = 1'b1; program_byte = 8'h41;
    tick();
    check("wrap_pc", 32'(pc), 32'h000);
    check("wrap_uaddr", 32'(ucode_addr), 32'h21);
    inc_pc = 1'b0;
    tick();

    // load_flags in fetch is ignored
    inc_pc = 1'b1; load_flags = 1'b1; alu_c = 1'b1; alu_z = 1'b0;
    tick();
    check("flg_f_uaddr", 32'(ucode_addr), 32'h21);
    // load_flags in exec captures C=1, Z=0
    inc_pc = 1'b0;
    tick();
    check("flg_e_uaddr", 32'(ucode_addr), 32'h24);
    check("flg_e_c", 32'(ucode_addr[2]), 32'h1);
    check("flg_e_z", 32'(ucode_addr[1]), 32'h0);

    // Next instruction: flags held through fetch, then C=0, Z=1
    load_flags = 1'b0; inc_pc = 1'b1; program_byte = 8'h70;
    tick();
    check("f3_uaddr", 32'(ucode_addr), 32'h3D);
    check("f3_pc", 32'(pc), 32'h2);
    inc_pc = 1'b0; load_flags = 1'b1; alu_c = 1'b0; alu_z = 1'b1;
    tick();
    check("e3_uaddr", 32'(ucode_addr), 32'h3A);
    load_flags = 1'b0;

    // Reset during exec of pc=5
    load_pc = 1'b1; pc_load_value = 12'h005; program_byte = 8'hF3;
    tick();
    check("r_pre_pc", 32'(pc), 32'h5);
    check("r_pre_phase", 32'(phase), 32'h1);
    load_pc = 1'b0; inc_pc = 1'b1; rst_n = 1'b0;
    tick();
    check("r_pc", 32'(pc), 32'h0);
    check("r_phase", 32'(phase), 32'h0);
    check("r_uaddr", 32'(ucode_addr), 32'h00);
    check("r_operand", 32'(operand), 32'h0);
    rst_n = 1'b1;
    tick();
    check("r_refetch_pc", 32'(pc), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
